// File: rtl/key_debounce.sv
// Per-key synchroniser, debouncer and hold/auto-repeat event generator.
// The outputs are a clean pressed level plus single-cycle press/release/long/repeat pulses.
module key_debounce #(
  parameter int          KEY_NUM       = 4,
  parameter logic [31:0] DEBOUNCE_MAX  = 32'd1_000_000,
  parameter logic [31:0] LONG_MAX      = 32'd100_000_000,
  parameter logic [31:0] REPEAT_MAX    = 32'd20_000_000,
  parameter logic        PRESSED_LEVEL = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} hold_state_t;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    logic        sync_p0, sync_p1;
    logic        key_sync;
    logic [31:0] deb_cnt, deb_cnt_nxt;
    logic        state_q, state_nxt;
    hold_state_t hold_st, hold_st_nxt;
    logic [31:0] hold_cnt, hold_cnt_nxt;
    logic        press_q, release_q, long_q, repeat_q;
    logic        press_nxt, release_nxt, long_nxt, repeat_nxt;

    assign key_sync = (sync_p1 == PRESSED_LEVEL);

    always_comb begin
      deb_cnt_nxt  = '0;
      state_nxt    = state_q;
      press_nxt    = 1'b0;
      release_nxt  = 1'b0;
      long_nxt     = 1'b0;
      repeat_nxt   = 1'b0;
      hold_st_nxt  = hold_st;
      hold_cnt_nxt = hold_cnt;

      // A level is accepted only after DEBOUNCE_MAX consecutive mismatching edges.
      if (key_sync != state_q) begin
        if (deb_cnt == DEBOUNCE_MAX - 32'd1) begin
          state_nxt   = key_sync;
          press_nxt   = key_sync;
          release_nxt = ~key_sync;
        end else begin
          deb_cnt_nxt = deb_cnt + 32'd1;
        end
      end

      // Release wins over a long/repeat event landing on the same edge.
      if (release_nxt) begin
        hold_st_nxt  = ST_IDLE;
        hold_cnt_nxt = '0;
      end else begin
        unique case (hold_st)
          ST_IDLE: begin
            if (press_nxt) begin
              hold_st_nxt  = ST_HOLD;
              hold_cnt_nxt = '0;
            end
          end
          ST_HOLD: begin
            if (hold_cnt == LONG_MAX - 32'd1) begin
              long_nxt     = 1'b1;
              hold_cnt_nxt = '0;
              hold_st_nxt  = ST_REPEAT;
            end else begin
              hold_cnt_nxt = hold_cnt + 32'd1;
            end
          end
          ST_REPEAT: begin
            if (hold_cnt == REPEAT_MAX - 32'd1) begin
              repeat_nxt   = 1'b1;
              hold_cnt_nxt = '0;
            end else begin
              hold_cnt_nxt = hold_cnt + 32'd1;
            end
          end
          default: begin
            hold_st_nxt  = ST_IDLE;
            hold_cnt_nxt = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        sync_p0   <= ~PRESSED_LEVEL;
        sync_p1   <= ~PRESSED_LEVEL;
        deb_cnt   <= '0;
        state_q   <= 1'b0;
        hold_st   <= ST_IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync_p0   <= key_in[i];
        sync_p1   <= sync_p0;
        deb_cnt   <= deb_cnt_nxt;
        state_q   <= state_nxt;
        hold_st   <= hold_st_nxt;
        hold_cnt  <= hold_cnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
        repeat_q  <= repeat_nxt;
      end
    end

    assign key_state[i]   = state_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity,
// all checked cycle by cycle against an elapsed-time reference model.
module tb_key_debounce;
  localparam int KN  = 4;
  localparam int DEB = 4;
  localparam int LNG = 10;
  localparam int REP = 5;
  localparam logic PL = 1'b0;

  logic          clock;
  logic          reset;
  logic [KN-1:0] key_in;
  logic [KN-1:0] key_state, key_press, key_release, key_long, key_repeat;

  key_debounce #(
    .KEY_NUM(KN), .DEBOUNCE_MAX(32'd4), .LONG_MAX(32'd10),
    .REPEAT_MAX(32'd5), .PRESSED_LEVEL(PL)
  ) dut (
    .clock(clock), .reset(reset), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: raw levels delayed two edges, a run-length of mismatching
  // edges, and the number of edges elapsed since the accepted press.
  bit            d1 [KN];
  bit            d2 [KN];
  int            run [KN];
  int            held [KN];
  logic [KN-1:0] m_state, m_press, m_rel, m_long, m_rep;

  task automatic model_edge();
    for (int k = 0; k < KN; k++) begin
      bit sync;
      m_press[k] = 1'b0; m_rel[k] = 1'b0; m_long[k] = 1'b0; m_rep[k] = 1'b0;
      if (reset) begin
        d1[k] = 1'b0; d2[k] = 1'b0; run[k] = 0; held[k] = -1; m_state[k] = 1'b0;
      end else begin
        sync = d2[k];
        if (sync != m_state[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == DEB) begin
          m_state[k] = sync;
          run[k] = 0;
          if (sync) m_press[k] = 1'b1;
          else      m_rel[k]   = 1'b1;
        end
        if (m_rel[k]) held[k] = -1;
        else if (m_press[k]) held[k] = 0;
        else if (held[k] >= 0) begin
          held[k]++;
          if (held[k] == LNG) m_long[k] = 1'b1;
          else if (held[k] > LNG && (held[k] - LNG) % REP == 0) m_rep[k] = 1'b1;
        end
        d2[k] = d1[k];
        d1[k] = (key_in[k] == PL);
      end
    end
  endtask

  task automatic step(input logic [KN-1:0] kin, input logic rst_v);
    key_in = kin;
    reset  = rst_v;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_vec("state",   {28'd0, key_state},   {28'd0, m_state});
    check_vec("press",   {28'd0, key_press},   {28'd0, m_press});
    check_vec("release", {28'd0, key_release}, {28'd0, m_rel});
    check_vec("long",    {28'd0, key_long},    {28'd0, m_long});
    check_vec("repeat",  {28'd0, key_repeat},  {28'd0, m_rep});
  endtask

  task automatic hold_steps(input logic [KN-1:0] kin, input int n);
    for (int s = 0; s < n; s++) step(kin, 1'b0);
  endtask

  initial begin
    logic [KN-1:0] target;
    logic [KN-1:0] acc;
    key_in = '1;
    reset  = 1'b1;
    m_state = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
    for (int k = 0; k < KN; k++) begin d1[k] = 0; d2[k] = 0; run[k] = 0; held[k] = -1; end

    // Reset behaviour, then a key held through reset
    repeat (3) step(4'b1111, 1'b1);
    check_vec("rst_state", {28'd0, key_state}, 32'd0);
    check_vec("rst_pulses", {28'd0, key_press | key_release | key_long | key_repeat}, 32'd0);
    repeat (2) step(4'b1110, 1'b1);
    check_vec("rst_held_press", {28'd0, key_press}, 32'd0);
    hold_steps(4'b1110, 5);
    check_vec("early_press", {28'd0, key_press}, 32'd0);
    step(4'b1110, 1'b0);
    check_vec("post_rst_press", {28'd0, key_press}, 32'd1);
    hold_steps(4'b1111, 6);
    check_vec("rel0", {28'd0, key_release}, 32'd1);

    // Clean press at e0, release input at e20
    hold_steps(4'b1111, 3);
    hold_steps(4'b1110, 6);
    check_vec("clean_press", {28'd0, key_press}, 32'd1);
    check_vec("clean_state", {28'd0, key_state}, 32'd1);
    hold_steps(4'b1110, 14);
    hold_steps(4'b1111, 6);
    check_vec("clean_rel", {28'd0, key_release}, 32'd1);
    check_vec("clean_rel_norep", {28'd0, key_repeat}, 32'd0);
    check_vec("clean_rel_state", {28'd0, key_state}, 32'd0);

    // Bounce on key1 is ignored, stable low is accepted
    acc = '0;
    for (int c = 0; c < 16; c++) begin
      step((c < 3 || (c >= 5 && c < 8)) ? 4'b1101 : 4'b1111, 1'b0);
      acc |= key_press | key_state;
    end
    check_vec("bounce", {28'd0, acc}, 32'd0);
    hold_steps(4'b1101, 6);
    check_vec("bounce_press", {28'd0, key_press}, 32'd2);
    hold_steps(4'b1111, 8);

    // Long press and repeat on key2, release on a repeat slot
    hold_steps(4'b1011, 6);
    check_vec("k2_press", {28'd0, key_press}, 32'd4);
    for (int k = 1; k <= 40; k++) begin
      step((k >= 35) ? 4'b1111 : 4'b1011, 1'b0);
      if (k == 10) check_vec("k2_long", {28'd0, key_long}, 32'd4);
      if (k == 15 || k == 20) check_vec("k2_repeat", {28'd0, key_repeat}, 32'd4);
      if (k == 40) begin
        check_vec("k2_rel", {28'd0, key_release}, 32'd4);
        check_vec("k2_rel_norep", {28'd0, key_repeat}, 32'd0);
      end
    end
    hold_steps(4'b1111, 4);

    // Simultaneous press, reset mid-hold, fresh press afterwards
    hold_steps(4'b0110, 6);
    check_vec("simul_press", {28'd0, key_press}, 32'h9);
    hold_steps(4'b0110, 6);
    step(4'b0111, 1'b1);
    check_vec("midrst_state", {28'd0, key_state}, 32'd0);
    hold_steps(4'b0111, 6);
    check_vec("fresh_press", {28'd0, key_press}, 32'h8);
    hold_steps(4'b0111, 10);
    check_vec("fresh_long", {28'd0, key_long}, 32'h8);
    hold_steps(4'b1111, 8);

    // Random activity with bounces and occasional resets
    target = '1;
    for (int c = 0; c < 1500; c++) begin
      logic [KN-1:0] kin;
      for (int k = 0; k < KN; k++)
        if ($urandom_range(29) == 0) target[k] = ~target[k];
      kin = target;
      for (int k = 0; k < KN; k++)
        if ($urandom_range(9) == 0) kin[k] = ~kin[k];
      step(kin, ($urandom_range(299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
